axis_producer: RTL and testbench
================================

Name: axis_producer

Overview:
- AXI-Stream packet source and the transmit-side counterpart of the team's AXI-Stream sink blocks.
- On a start pulse it emits a programmable number of fixed-length packets. Each beat carries a replicated 32-bit incrementing counter pattern.
- Packets can be separated by an optional idle gap.
- Used as a traffic/test-pattern source driving any AXIS slave in the design.

Parameters:
- DATA_WIDTH, 256: AXIS data width in bits. Must be a multiple of 32.
- LEN_WIDTH, 16: width of the packet-length input (beats per packet).

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse that begins a run; sampled only in IDLE
- packet_len  input  LEN_WIDTH  beats per packet, sampled on start
- packet_count  input  32  packets per run, sampled on start
- gap  input  8  idle cycles between packets, sampled on start
- first_value  input  32  initial pattern counter value, sampled on start
- busy  output  1  high from the cycle after start until run complete
- done  output  1  one-cycle pulse at run completion
- AXIS_TDATA  output  DATA_WIDTH  pattern word
- AXIS_TVALID  output  1  beat valid
- AXIS_TLAST  output  1  final beat of a packet
- AXIS_TREADY  input  1  downstream ready

Behaviour:
- Reset (resetn low at a rising edge): state IDLE; AXIS_TVALID, AXIS_TLAST, busy and done go to 0; AXIS_TDATA goes to 0; all counters are cleared. Reset mid-packet aborts immediately. No partial-packet completion.
- All outputs are registered.
- Handshake: a beat transfers on a clk edge where AXIS_TVALID & AXIS_TREADY.
  - Once TVALID is asserted, TVALID, TDATA and TLAST hold until that handshake.
  - TVALID never depends combinationally on TREADY.
  - TREADY held low indefinitely stalls the block with no data change.
- FSM states: IDLE, SEND, GAP, FINISH.
- IDLE:
  - start with packet_len != 0 and packet_count != 0 latches the inputs and goes to SEND. On the next cycle busy=1, TVALID=1, TDATA = first_value replicated, and TLAST=(packet_len==1).
  - start with packet_len==0 or packet_count==0 goes to FINISH. No beats are sent.
  - start while not IDLE is ignored.
- SEND, on each handshake:
  - The pattern counter increments by 1, wrapping 0xFFFFFFFF to 0x00000000.
  - The beat counter increments.
  - TDATA for the next beat is the new counter replicated DATA_WIDTH/32 times.
  - TLAST is asserted exactly on beat packet_len of each packet.
- Handshake on a TLAST beat:
  - Last packet: go to FINISH, TVALID=0.
  - More packets, gap==0: stay in SEND, TVALID stays 1, and the next packet's first beat is presented the next cycle (back-to-back).
  - More packets, gap>0: go to GAP, TVALID=0 for exactly gap cycles, then return to SEND with TVALID=1.
- The pattern counter is continuous across packet boundaries. It is not reloaded per packet.
- FINISH: done=1 and busy=0 for one cycle, then IDLE with done=0. done asserts the cycle after the final handshake.
- A start coincident with the done cycle is ignored. A start is accepted from the following cycle.
- Latency: start edge to first TVALID is 1 cycle. The last handshake to done is 1 cycle.
- Packet and beat counters are 32-bit and LEN_WIDTH-bit respectively. Comparisons are unsigned. packet_len at maximum (2^LEN_WIDTH−1) is legal.

Decomposition:
- Shared package axis_pkg holds:
  - the state enum (IDLE, SEND, GAP, FINISH);
  - the constant PATTERN_WIDTH = 32;
  - a function replicating a 32-bit value to DATA_WIDTH.
- No sub-module is required. The FSM, counters and output register are a single block.

Test Plan:
- packet_len=4, packet_count=1, gap=0, first_value=0x10, TREADY=1 -> four beats 0x10..0x13 (replicated), TLAST on 0x13, done one cycle after last beat, busy high 4 cycles.
- packet_len=3, packet_count=2, gap=2, first_value=0 -> beats 0,1,2(TLAST), 2 cycles TVALID=0, then 3,4,5(TLAST), done.
- packet_len=5, TREADY toggled pseudo-randomly (50%) -> TDATA/TLAST/TVALID stable while TREADY=0, sequence 0..4 intact, no beat lost or duplicated.
- first_value=0xFFFFFFFE, packet_len=4 -> data FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- packet_len=0 (and separately packet_count=0) -> no TVALID, done pulse on cycle after start; second start during busy of a normal run -> ignored, beat count unchanged.
- resetn low during beat 2 of 8 -> TVALID=0 next cycle, busy=0, done never pulses; a subsequent start runs a full clean packet.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream pattern blocks.
package axis_pkg;

  localparam int PATTERN_WIDTH  = 32;
  localparam int MAX_DATA_WIDTH = 2048;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FINISH
  } state_e;

  // Callers narrow the result to their own bus width with a size cast.
  function automatic logic [MAX_DATA_WIDTH-1:0] replicate(
    input logic [PATTERN_WIDTH-1:0] v
  );
    return {(MAX_DATA_WIDTH/PATTERN_WIDTH){v}};
  endfunction

endpackage

// File: rtl/axis_producer.sv
// AXI-Stream test-pattern source: packet_count packets of packet_len
// beats carrying a replicated, continuously incrementing 32-bit counter.
module axis_producer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  packet_len,
  input  logic [31:0]           packet_count,
  input  logic [7:0]            gap,
  input  logic [31:0]           first_value,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] AXIS_TDATA,
  output logic                  AXIS_TVALID,
  output logic                  AXIS_TLAST,
  input  logic                  AXIS_TREADY
);

  state_e                   state_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     beat_q;
  logic [31:0]              pkts_q;
  logic [7:0]               gap_q;
  logic [7:0]               gap_cnt_q;
  logic [PATTERN_WIDTH-1:0] pat_q;

  logic [PATTERN_WIDTH-1:0] pat_nxt;
  logic [LEN_WIDTH-1:0]     beat_nxt;
  logic                     len_one;
  logic                     xfer;

  assign pat_nxt  = pat_q + 32'd1;
  assign beat_nxt = beat_q + LEN_WIDTH'(1);
  assign len_one  = (len_q == LEN_WIDTH'(1));
  assign xfer     = AXIS_TVALID & AXIS_TREADY;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      pkts_q      <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      pat_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      AXIS_TDATA  <= '0;
      AXIS_TVALID <= 1'b0;
      AXIS_TLAST  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (packet_len != '0 && packet_count != 32'd0) begin
              state_q     <= SEND;
              len_q       <= packet_len;
              pkts_q      <= packet_count;
              gap_q       <= gap;
              beat_q      <= LEN_WIDTH'(1);
              pat_q       <= first_value;
              busy        <= 1'b1;
              AXIS_TDATA  <= DATA_WIDTH'(replicate(first_value));
              AXIS_TVALID <= 1'b1;
              AXIS_TLAST  <= (packet_len == LEN_WIDTH'(1));
            end else begin
              state_q <= FINISH;
              done    <= 1'b1;
            end
          end
        end

        SEND: begin
          if (xfer) begin
            pat_q <= pat_nxt;
            if (AXIS_TLAST) begin
              if (pkts_q == 32'd1) begin
                state_q     <= FINISH;
                busy        <= 1'b0;
                done        <= 1'b1;
                AXIS_TVALID <= 1'b0;
                AXIS_TLAST  <= 1'b0;
              end else begin
                pkts_q <= pkts_q - 32'd1;
                beat_q <= LEN_WIDTH'(1);
                if (gap_q == 8'd0) begin
                  AXIS_TDATA <= DATA_WIDTH'(replicate(pat_nxt));
                  AXIS_TLAST <= len_one;
                end else begin
                  state_q     <= GAP;
                  gap_cnt_q   <= gap_q;
                  AXIS_TVALID <= 1'b0;
                  AXIS_TLAST  <= 1'b0;
                end
              end
            end else begin
              beat_q     <= beat_nxt;
              AXIS_TDATA <= DATA_WIDTH'(replicate(pat_nxt));
              AXIS_TLAST <= (beat_nxt == len_q);
            end
          end
        end

        GAP: begin
          gap_cnt_q <= gap_cnt_q - 8'd1;
          // The last idle cycle preloads the next packet's first beat.
          if (gap_cnt_q == 8'd1) begin
            state_q     <= SEND;
            AXIS_TDATA  <= DATA_WIDTH'(replicate(pat_q));
            AXIS_TVALID <= 1'b1;
            AXIS_TLAST  <= len_one;
          end
        end

        FINISH: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_producer.sv
// Scoreboard bench for axis_producer: expected beats queued at start,
// popped and compared by a negedge monitor; tasks check run timing.
module tb_axis_producer;

  localparam int DW = 256;
  localparam int LW = 16;

  typedef struct packed {
    logic        last;
    logic [31:0] val;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] packet_len = '0;
  logic [31:0]   packet_count = '0;
  logic [7:0]    gap = '0;
  logic [31:0]   first_value = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b1;
  logic          rand_ready = 1'b0;

  int checks = 0;
  int passed = 0;
  beat_t exp_q[$];

  bit            stall_q = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  always #5 clk = ~clk;

  axis_producer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .packet_len   (packet_len),
    .packet_count (packet_count),
    .gap          (gap),
    .first_value  (first_value),
    .busy         (busy),
    .done         (done),
    .AXIS_TDATA   (tdata),
    .AXIS_TVALID  (tvalid),
    .AXIS_TLAST   (tlast),
    .AXIS_TREADY  (tready)
  );

  function automatic logic [DW-1:0] rep(input logic [31:0] v);
    return {(DW/32){v}};
  endfunction

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      tready = ($urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (resetn === 1'b1) begin
      if (stall_q) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== hold_data || tlast !== hold_last)
          $display("FAIL stall_hold: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   tvalid, tlast, tdata[31:0], hold_last, hold_data[31:0]);
        else
          passed++;
      end
      if (tvalid === 1'b1 && tready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat: got d=%h l=%b want none",
                   tdata[31:0], tlast);
        end else begin
          e = exp_q.pop_front();
          if (tdata !== rep(e.val) || tlast !== e.last)
            $display("FAIL beat: got d=%h l=%b want d=%h l=%b",
                     tdata, tlast, rep(e.val), e.last);
          else
            passed++;
        end
      end
      stall_q   = (tvalid === 1'b1) && (tready !== 1'b1);
      hold_data = tdata;
      hold_last = tlast;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic launch(input logic [LW-1:0] len, input logic [31:0] cnt,
                        input logic [7:0] g, input logic [31:0] fv);
    logic [31:0] v;
    v = fv;
    if (len != '0 && cnt != 32'd0)
      for (int p = 0; p < int'(cnt); p++)
        for (int b = 0; b < int'(len); b++) begin
          exp_q.push_back('{last: (b == int'(len) - 1), val: v});
          v = v + 32'd1;
        end
    @(posedge clk); #1;
    packet_len   = len;
    packet_count = cnt;
    gap          = g;
    first_value  = fv;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc,
                           output int busy_n, output logic [31:0] vpat);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    busy_n = 0;
    vpat = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      vpat = {vpat[30:0], tvalid === 1'b1};
      if (busy === 1'b1) busy_n++;
      cyc++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL done_timeout: got no done in %0d cycles want done", budget);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (tvalid !== 1'b0) $display("FAIL rst_valid: got %b want 0", tvalid); else passed++;
    checks++; if (tlast !== 1'b0) $display("FAIL rst_last: got %b want 0", tlast); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    checks++; if (tdata !== '0) $display("FAIL rst_data: got %h want 0", tdata); else passed++;
  endtask

  task automatic test_single;
    int cyc, bn;
    logic [31:0] vp;
    launch(4, 1, 0, 32'h10);
    wait_done(40, cyc, bn, vp);
    checks++; if (cyc != 4) $display("FAIL single_latency: got %0d want 4", cyc); else passed++;
    checks++; if (bn != 4) $display("FAIL single_busy: got %0d want 4", bn); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", done); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL single_left: got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_gap;
    int cyc, bn;
    logic [31:0] vp;
    launch(3, 2, 2, 32'h0);
    wait_done(60, cyc, bn, vp);
    checks++; if (cyc != 8) $display("FAIL gap_len: got %0d want 8", cyc); else passed++;
    checks++; if (vp[7:0] !== 8'b1110_0111) $display("FAIL gap_valid: got %b want 11100111", vp[7:0]); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL gap_left: got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_stall;
    int cyc, bn;
    logic [31:0] vp;
    rand_ready = 1'b1;
    launch(5, 2, 1, 32'h100);
    wait_done(400, cyc, bn, vp);
    rand_ready = 1'b0;
    @(posedge clk); #2;
    tready = 1'b1;
    checks++; if (exp_q.size() != 0) $display("FAIL stall_left: got %0d want 0", exp_q.size()); else passed++;
    checks++; if (cyc < 11) $display("FAIL stall_len: got %0d want >=11", cyc); else passed++;
  endtask

  task automatic test_wrap;
    int cyc, bn;
    logic [31:0] vp;
    launch(4, 1, 0, 32'hFFFF_FFFE);
    wait_done(40, cyc, bn, vp);
    checks++; if (cyc != 4) $display("FAIL wrap_len: got %0d want 4", cyc); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL wrap_left: got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_zero;
    int cyc, bn;
    logic [31:0] vp;
    launch(0, 3, 0, 32'h7);
    wait_done(10, cyc, bn, vp);
    checks++; if (cyc != 0) $display("FAIL zero_len_done: got %0d want 0", cyc); else passed++;
    launch(3, 0, 0, 32'h7);
    wait_done(10, cyc, bn, vp);
    checks++; if (cyc != 0) $display("FAIL zero_cnt_done: got %0d want 0", cyc); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL zero_left: got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_ignore;
    int cyc, bn, seen;
    logic [31:0] vp;
    launch(6, 1, 0, 32'h200);
    @(posedge clk); #1;
    packet_len  = 2;
    first_value = 32'h999;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, cyc, bn, vp);
    checks++; if (cyc != 4) $display("FAIL ignore_len: got %0d want 4", cyc); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL ignore_left: got %0d want 0", exp_q.size()); else passed++;
    // start raised while done is high must be dropped
    packet_len   = 2;
    packet_count = 1;
    first_value  = 32'h0;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tvalid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) $display("FAIL done_start: got %0d active cycles want 0", seen); else passed++;
  endtask

  task automatic test_reset_mid;
    int cyc, bn, seen;
    logic [31:0] vp;
    launch(8, 1, 0, 32'h300);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++; if (tvalid !== 1'b0) $display("FAIL mid_valid: got %b want 0", tvalid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || tvalid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) $display("FAIL mid_quiet: got %0d active cycles want 0", seen); else passed++;
    launch(3, 1, 0, 32'h55);
    wait_done(40, cyc, bn, vp);
    checks++; if (cyc != 3) $display("FAIL mid_rerun: got %0d want 3", cyc); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL mid_left: got %0d want 0", exp_q.size()); else passed++;
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    #1;
    resetn = 1'b1;
    test_single;
    test_gap;
    test_stall;
    test_wrap;
    test_zero;
    test_ignore;
    test_reset_mid;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
